// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state type and helpers for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
  // Returns {borrow_out, difference} of a - b - bin
  function automatic logic [1:0] fsub(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit combinational full subtractor
module full_subtractor_bit
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign {bout, d} = fsub(a, b, bin);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: LSB-first bit-serial a - b - bin with start/done handshake
module serial_ripple_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CNT_W = cnt_width(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, d_next;
  logic [WIDTH-2:0] d_sr;
  logic [CNT_W-1:0] cnt;
  logic br, d, bout;
  full_subtractor_bit u_fs (.a(a_sr[0]), .b(b_sr[0]), .bin(br), .d(d), .bout(bout));
  // d_sr holds the bits finished so far; the current bit completes the word
  assign d_next = {d, d_sr};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          a_sr  <= a;
          b_sr  <= b;
          br    <= bin;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next[WIDTH-1:1];
          br   <= bout;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state  <= DONE;
            diff   <= d_next;
            borrow <= bout;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: directed, exhaustive (WIDTH=4) and random (WIDTH=8) checks
module tb_serial_ripple_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  logic start4 = 1'b0, bin4 = 1'b0, busy4, done4, borrow4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic start8 = 1'b0, bin8 = 1'b0, busy8, done8, borrow8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  int n_vec = 0, n_err = 0, n_done4 = 0, n_overlap = 0;

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4));
  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done4) n_done4++;
    if ((busy4 && done4) || (busy8 && done8)) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // lat counts edges from acceptance (edge 0) to the edge that raises done
  task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic bi,
                     output logic [3:0] d, output logic bo, output int lat, output int nb);
    @(negedge clk);
    a4 = aa; b4 = bb; bin4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; lat = 1; nb = 0;
    while (!done4 && lat < 20) begin
      if (busy4) nb++;
      @(negedge clk);
      lat++;
    end
    d = diff4; bo = borrow4;
  endtask

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic bi,
                     output logic [7:0] d, output logic bo, output int lat);
    @(negedge clk);
    a8 = aa; b8 = bb; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    d = diff8; bo = borrow8;
  endtask

  logic [3:0] d4;
  logic [7:0] d8;
  logic bo;
  int lat, nb, nd;
  logic [4:0] ref5;
  logic [8:0] ref9;
  logic [3:0] ha [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
  logic [3:0] hb [8] = '{4'd8, 4'd14, 4'd12, 4'd8, 4'd11, 4'd6, 4'd1, 4'd9};
  logic [3:0] hd [8] = '{4'd8, 4'd3, 4'd6, 4'd11, 4'd9, 4'd15, 4'd5, 4'd14};
  logic       hbo [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #1;
    chk("reset_busy", 32'(busy4), 0);
    chk("reset_done", 32'(done4), 0);
    chk("reset_diff", 32'(diff4), 0);
    chk("reset_borrow", 32'(borrow4), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    op4(4'd9, 4'd3, 1'b0, d4, bo, lat, nb);
    chk("9-3_diff", 32'(d4), 6);
    chk("9-3_borrow", 32'(bo), 0);
    chk("9-3_latency", 32'(lat), 5);
    chk("9-3_busy_cycles", 32'(nb), 4);
    @(negedge clk);
    chk("done_one_cycle", 32'(done4), 0);
    chk("diff_holds", 32'(diff4), 6);

    op4(4'd3, 4'd9, 1'b0, d4, bo, lat, nb);
    chk("3-9_diff", 32'(d4), 10);
    chk("3-9_borrow", 32'(bo), 1);
    op4(4'd0, 4'd0, 1'b1, d4, bo, lat, nb);
    chk("0-0-1_diff", 32'(d4), 15);
    chk("0-0-1_borrow", 32'(bo), 1);
    op4(4'd5, 4'd5, 1'b0, d4, bo, lat, nb);
    chk("5-5_diff", 32'(d4), 0);
    chk("5-5_borrow", 32'(bo), 0);

    // start pulses during RUN must be ignored
    @(negedge clk);
    nd = n_done4;
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = 4'd15; b4 = 4'd0; start4 = (i < 3);
    end
    lat = 0;
    while (!done4 && lat < 20) begin @(negedge clk); lat++; end
    chk("repulse_diff", 32'(diff4), 6);
    chk("repulse_borrow", 32'(borrow4), 0);
    repeat (8) @(negedge clk);
    chk("repulse_done_count", 32'(n_done4 - nd), 1);

    // reset during third RUN cycle
    a4 = 4'd12; b4 = 4'd4; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk); @(negedge clk);
    nd = n_done4;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_diff", 32'(diff4), 0);
    chk("abort_borrow", 32'(borrow4), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(n_done4 - nd), 0);
    op4(4'd8, 4'd1, 1'b0, d4, bo, lat, nb);
    chk("8-1_diff", 32'(d4), 7);
    chk("8-1_borrow", 32'(bo), 0);

    // start held high: back-to-back operations every 6 cycles
    @(negedge clk);
    a4 = ha[0]; b4 = hb[0]; bin4 = 1'b0; start4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done4 && lat < 20);
      chk("held_diff", 32'(diff4), 32'(hd[k]));
      chk("held_borrow", 32'(borrow4), 32'(hbo[k]));
      if (k > 0) chk("held_spacing", 32'(lat), 6);
      if (k < 7) begin a4 = ha[k+1]; b4 = hb[k+1]; end
    end
    start4 = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 512; i++) begin
      op4(4'(i >> 5), 4'(i >> 1), i[0], d4, bo, lat, nb);
      ref5 = {1'b0, 4'(i >> 5)} - {1'b0, 4'(i >> 1)} - {4'd0, i[0]};
      chk("exh_diff", 32'(d4), 32'(ref5[3:0]));
      chk("exh_borrow", 32'(bo), 32'(ref5[4]));
    end

    op8(8'd0, 8'd0, 1'b1, d8, bo, lat);
    chk("w8_wrap_diff", 32'(d8), 255);
    chk("w8_wrap_borrow", 32'(bo), 1);
    chk("w8_latency", 32'(lat), 9);
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      bin8 = 1'($urandom);
      ref9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
      op8(a8, b8, bin8, d8, bo, lat);
      chk("w8_rand_diff", 32'(d8), 32'(ref9[7:0]));
      chk("w8_rand_borrow", 32'(bo), 32'(ref9[8]));
    end

    chk("busy_done_overlap", 32'(n_overlap), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial ripple-borrow subtractor, the subtraction counterpart of the team's 4-bit ripple-carry adder. It computes diff = a − b − bin one full-subtractor bit per clock, LSB first, through a single registered borrow. It is a handshaked, multi-cycle arithmetic unit: start launches an operation, done pulses when the result is valid, and it sits beside the combinational adder in the datapath library.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2–32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse: diff/borrow valid and final.
- diff  output  WIDTH  result, registered; holds its value between operations.
- borrow  output  1  final borrow-out, registered; 1 means a < b + bin (unsigned).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE → RUN on start = 1. This edge loads the a/b shift registers, loads the borrow register with bin, and clears bit counter cnt.
  - RUN: each edge processes bit cnt.
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - The a/b shift registers shift right. d enters the MSB of the diff shift register. cnt increments.
  - RUN → DONE on the edge that processes bit WIDTH−1 (cnt = WIDTH−1). On that edge, the diff output register and the borrow output register load the completed result.
  - DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. It is not queued, and a/b/bin changes during those states have no effect.
- Arithmetic is unsigned modulo 2^WIDTH: diff = (a − b − bin) mod 2^WIDTH and borrow = (a < b + bin).
- The diff/borrow outputs change only on the completion edge. Partial results are never visible.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, diff = 0, borrow = 0. The internal shift registers, cnt and the borrow register are also cleared.
- Edge numbering counts the accepting edge as edge 0.
  - busy is high after edge 0 and low after edge WIDTH.
  - done is high after edge WIDTH and low after edge WIDTH+1.
- Latency: WIDTH+1 edges from acceptance to done. Minimum start-to-start spacing is WIDTH+2 cycles. start may be held high continuously and is re-accepted on the first edge in IDLE.
- busy and done are never high in the same cycle.
- Reset asserted mid-operation: abort immediately. All outputs return to their reset values, no done pulse is produced, and the previous diff is lost.
- Edge cases that must produce the correct result:
  - a = b with bin = 0: diff = 0, borrow = 0.
  - a = 0, b = 0, bin = 1: full wrap to all-ones, borrow = 1.

## Structure
- Package serial_sub_pkg holds:
  - the state typedef enum (IDLE, RUN, DONE);
  - localparam CNT_W = $clog2(WIDTH) (helper function form);
  - the full-subtractor bit function.
- Sub-module full_subtractor_bit is purely combinational (inputs a, b, bin; outputs d, bout) and is instantiated once in the RUN datapath.
- The top-level module contains the FSM, the counter, the three shift registers and the output registers.

## Test plan
- WIDTH = 4, a = 9, b = 3, bin = 0, start pulse → busy for 4 cycles, then done with diff = 6, borrow = 0.
- a = 3, b = 9, bin = 0 → diff = 4'b1010 (10), borrow = 1. a = 0, b = 0, bin = 1 → diff = 15, borrow = 1.
- start re-pulsed at cycles 1–3 of RUN with a = 15, b = 0 → ignored. Result stays 9 − 3 = 6 and exactly one done pulse is seen.
- rst asserted during the third RUN cycle → busy = 0, diff = 0, borrow = 0 immediately. No done pulse. The next operation, 8 − 1, returns 7.
- start held high with operands stepping through the adder bench's vector set (0−8, 1−14, 2−12, 3−8, 4−11, 5−6, 6−1, 7−9) → operations are accepted every 6 cycles. Each result must match (a − b) mod 16 and the expected borrow.
- Exhaustive self-check over all a, b, bin for WIDTH = 4 against a reference model, plus a random check at WIDTH = 8.
